// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single memory port between icache loads and dcache loads/stores, tracks tag ownership, routes returns.
// Latency: grant, command forwarding and accept-tag return are combinational; the owner table updates at the next clock edge.
// Backpressure: a rejected command (accept tag 0) is re-presented by its requester; arbitration state only advances on acceptance.
module mem_port_arbiter #(
  parameter int  NUM_TAGS     = 16,
  parameter int  STARVE_LIMIT = 4,
  // STARVE_LIMIT must be representable: STARVE_LIMIT < 2**CNT_WIDTH
  parameter int  CNT_WIDTH    = 3,
  localparam int TAG_W        = $clog2(NUM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       proc2Imem_command,
  input  logic [31:0]      proc2Imem_addr,
  input  logic [1:0]       proc2Dmem_command,
  input  logic [31:0]      proc2Dmem_addr,
  input  logic [63:0]      proc2Dmem_data,
  input  logic [TAG_W-1:0] mem2proc_transaction_tag,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_data_tag,
  output logic [1:0]       proc2mem_command,
  output logic [31:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] Imem2proc_transaction_tag,
  output logic [63:0]      Imem2proc_data,
  output logic [TAG_W-1:0] Imem2proc_data_tag,
  output logic [TAG_W-1:0] Dmem2proc_transaction_tag,
  output logic [63:0]      Dmem2proc_data,
  output logic [TAG_W-1:0] Dmem2proc_data_tag,
  output logic             stale_tag_err
);

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_e;

  typedef struct packed {
    logic vld;
    req_e owner;
  } owner_t;

  // Arbitration state
  owner_t               owner_tbl [NUM_TAGS];
  req_e                 rr_ptr;        // load requester that wins the next load-vs-load tie
  logic [CNT_WIDTH-1:0] starve_cnt;    // consecutive accepted stores while a load waited
  logic                 stale_err_q;

  // Request decode
  logic i_load_req;
  logic d_load_req;
  logic d_store_req;
  logic load_pending;
  logic starving;

  // Grant and acceptance
  logic gnt_vld;
  req_e gnt_req;
  logic gnt_store;
  logic gnt_load;
  logic tag_accepted;
  logic load_acc;
  logic store_acc;

  // Return path
  owner_t ret_entry;
  logic   ret_vld;
  logic   ret_hit;
  logic   ret_stale;
  logic   alloc_clash;

  assign i_load_req   = (proc2Imem_command == MEM_LOAD);
  assign d_load_req   = (proc2Dmem_command == MEM_LOAD);
  assign d_store_req  = (proc2Dmem_command == MEM_STORE);
  assign load_pending = i_load_req | d_load_req;
  assign starving     = (starve_cnt == CNT_WIDTH'(STARVE_LIMIT));

  // Pick the requester: stores first unless a load has starved, then round-robin between loads
  always_comb begin
    gnt_vld = 1'b0;
    gnt_req = REQ_ICACHE;
    if (d_store_req && !(starving && i_load_req)) begin
      gnt_vld = 1'b1;
      gnt_req = REQ_DCACHE;
    end else if (i_load_req && d_load_req) begin
      gnt_vld = 1'b1;
      gnt_req = rr_ptr;
    end else if (i_load_req) begin
      gnt_vld = 1'b1;
      gnt_req = REQ_ICACHE;
    end else if (d_load_req) begin
      gnt_vld = 1'b1;
      gnt_req = REQ_DCACHE;
    end
  end

  assign gnt_store    = gnt_vld && (gnt_req == REQ_DCACHE) && d_store_req;
  assign gnt_load     = gnt_vld && !gnt_store;
  assign tag_accepted = (mem2proc_transaction_tag != '0);
  assign load_acc     = gnt_load && tag_accepted;
  assign store_acc    = gnt_store && tag_accepted;

  // Return lookup; an entry freed by this cycle's return may be legally reallocated in the same cycle
  assign ret_entry   = owner_tbl[mem2proc_data_tag];
  assign ret_vld     = (mem2proc_data_tag != '0);
  assign ret_hit     = ret_vld && ret_entry.vld;
  assign ret_stale   = ret_vld && !ret_entry.vld;
  assign alloc_clash = load_acc && owner_tbl[mem2proc_transaction_tag].vld &&
                       !(ret_hit && (mem2proc_data_tag == mem2proc_transaction_tag));

  // Drive the memory port and accept tags from the granted requester; everything is quiet during reset
  always_comb begin
    proc2mem_command          = MEM_NONE;
    proc2mem_addr             = '0;
    proc2mem_data             = '0;
    Imem2proc_transaction_tag = '0;
    Dmem2proc_transaction_tag = '0;
    if (reset && gnt_vld) begin
      if (gnt_req == REQ_DCACHE) begin
        proc2mem_command          = proc2Dmem_command;
        proc2mem_addr             = proc2Dmem_addr;
        proc2mem_data             = proc2Dmem_data;
        Dmem2proc_transaction_tag = mem2proc_transaction_tag;
      end else begin
        proc2mem_command          = proc2Imem_command;
        proc2mem_addr             = proc2Imem_addr;
        Imem2proc_transaction_tag = mem2proc_transaction_tag;
      end
    end
  end

  // Steer a returning block to the recorded owner only
  always_comb begin
    Imem2proc_data     = '0;
    Imem2proc_data_tag = '0;
    Dmem2proc_data     = '0;
    Dmem2proc_data_tag = '0;
    if (reset && ret_hit) begin
      if (ret_entry.owner == REQ_DCACHE) begin
        Dmem2proc_data     = mem2proc_data;
        Dmem2proc_data_tag = mem2proc_data_tag;
      end else begin
        Imem2proc_data     = mem2proc_data;
        Imem2proc_data_tag = mem2proc_data_tag;
      end
    end
  end

  // Owner table: a return clears its entry, an accepted load claims one; allocation wins on a same-tag collision
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        owner_tbl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (load_acc && (mem2proc_transaction_tag == TAG_W'(i))) begin
          owner_tbl[i] <= '{vld: 1'b1, owner: gnt_req};
        end else if (ret_hit && (mem2proc_data_tag == TAG_W'(i))) begin
          owner_tbl[i].vld <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer hands the next tie to the load requester that was not just served
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= REQ_ICACHE;
    end else if (load_acc) begin
      rr_ptr <= (gnt_req == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
    end
  end

  // Starvation counter: counts stores accepted over a waiting load, cleared by any load acceptance or no load waiting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (load_acc || !load_pending) begin
      starve_cnt <= '0;
    end else if (store_acc) begin
      starve_cnt <= starve_cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky protocol error: return of an unowned tag, or allocation over a live tag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stale_err_q <= 1'b0;
    end else if (ret_stale || alloc_clash) begin
      stale_err_q <= 1'b1;
    end
  end

  assign stale_tag_err = stale_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a tag-table reference model.
// Inputs change on the falling edge; outputs are compared 1 time unit later, model state advances on the rising edge.
// Randomized phase first keeps memory legal (free tags only), then injects stale returns and live-tag reallocation.
module tb_mem_port_arbiter;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;
  localparam int STARVE_LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  proc2Imem_command;
  logic [31:0] proc2Imem_addr;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_data_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  Imem2proc_transaction_tag;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_data_tag;
  logic [3:0]  Dmem2proc_transaction_tag;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_data_tag;
  logic        stale_tag_err;

  mem_port_arbiter #(.NUM_TAGS(16), .STARVE_LIMIT(STARVE_LIMIT), .CNT_WIDTH(3)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .proc2Imem_command        (proc2Imem_command),
    .proc2Imem_addr           (proc2Imem_addr),
    .proc2Dmem_command        (proc2Dmem_command),
    .proc2Dmem_addr           (proc2Dmem_addr),
    .proc2Dmem_data           (proc2Dmem_data),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .Imem2proc_transaction_tag(Imem2proc_transaction_tag),
    .Imem2proc_data           (Imem2proc_data),
    .Imem2proc_data_tag       (Imem2proc_data_tag),
    .Dmem2proc_transaction_tag(Dmem2proc_transaction_tag),
    .Dmem2proc_data           (Dmem2proc_data),
    .Dmem2proc_data_tag       (Dmem2proc_data_tag),
    .stale_tag_err            (stale_tag_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns each tag (1 = icache, 2 = dcache), whose turn a load tie is, starvation count
  bit m_vld [16];
  int m_own [16];
  int m_rr;
  int m_cnt;
  bit m_stale;

  // Expected outputs for the current cycle
  int          e_win;  // 0 none, 1 icache, 2 dcache
  logic [1:0]  e_cmd;
  logic [31:0] e_addr;
  logic [63:0] e_data, e_ird, e_drd;
  logic [3:0]  e_itag, e_dtag, e_irt, e_drt;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 16; t++) begin
      m_vld[t] = 1'b0;
      m_own[t] = 0;
    end
    m_rr    = 1;
    m_cnt   = 0;
    m_stale = 1'b0;
  endtask

  task automatic model_eval();
    bit i_ld, d_ld, d_st;
    i_ld = (proc2Imem_command == MEM_LOAD);
    d_ld = (proc2Dmem_command == MEM_LOAD);
    d_st = (proc2Dmem_command == MEM_STORE);
    if (d_st && !(i_ld && m_cnt == STARVE_LIMIT)) e_win = 2;
    else if (i_ld && d_ld)                        e_win = m_rr;
    else if (i_ld)                                e_win = 1;
    else if (d_ld)                                e_win = 2;
    else                                          e_win = 0;
    e_cmd = MEM_NONE; e_addr = '0; e_data = '0; e_itag = '0; e_dtag = '0;
    if (e_win == 1) begin
      e_cmd = MEM_LOAD; e_addr = proc2Imem_addr; e_itag = mem2proc_transaction_tag;
    end else if (e_win == 2) begin
      e_cmd = proc2Dmem_command; e_addr = proc2Dmem_addr; e_data = proc2Dmem_data;
      e_dtag = mem2proc_transaction_tag;
    end
    e_irt = '0; e_ird = '0; e_drt = '0; e_drd = '0;
    if (mem2proc_data_tag != 0 && m_vld[mem2proc_data_tag]) begin
      if (m_own[mem2proc_data_tag] == 1) begin
        e_irt = mem2proc_data_tag; e_ird = mem2proc_data;
      end else begin
        e_drt = mem2proc_data_tag; e_drd = mem2proc_data;
      end
    end
  endtask

  task automatic check_model();
    model_eval();
    check_val("cmd",   proc2mem_command,          e_cmd);
    check_val("addr",  proc2mem_addr,             e_addr);
    check_val("wdata", proc2mem_data,             e_data);
    check_val("i_tt",  Imem2proc_transaction_tag, e_itag);
    check_val("d_tt",  Dmem2proc_transaction_tag, e_dtag);
    check_val("i_rt",  Imem2proc_data_tag,        e_irt);
    check_val("i_rd",  Imem2proc_data,            e_ird);
    check_val("d_rt",  Dmem2proc_data_tag,        e_drt);
    check_val("d_rd",  Dmem2proc_data,            e_drd);
    check_val("stale", stale_tag_err,             m_stale);
  endtask

  // Advance the model across the rising edge using the inputs still held on the pins
  task automatic step();
    bit any_ld, ld_acc, st_acc;
    @(posedge clock);
    any_ld = (proc2Imem_command == MEM_LOAD) || (proc2Dmem_command == MEM_LOAD);
    ld_acc = (mem2proc_transaction_tag != 0) &&
             (e_win == 1 || (e_win == 2 && proc2Dmem_command == MEM_LOAD));
    st_acc = (mem2proc_transaction_tag != 0) && e_win == 2 && proc2Dmem_command == MEM_STORE;
    if (mem2proc_data_tag != 0) begin
      if (m_vld[mem2proc_data_tag]) m_vld[mem2proc_data_tag] = 1'b0;
      else                          m_stale = 1'b1;
    end
    if (ld_acc) begin
      if (m_vld[mem2proc_transaction_tag]) m_stale = 1'b1;
      m_vld[mem2proc_transaction_tag] = 1'b1;
      m_own[mem2proc_transaction_tag] = e_win;
      m_rr = (e_win == 1) ? 2 : 1;
    end
    if (ld_acc || !any_ld) m_cnt = 0;
    else if (st_acc)       m_cnt = m_cnt + 1;
  endtask

  task automatic apply(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                       input logic [31:0] da, input logic [63:0] dd, input logic [3:0] mt,
                       input logic [3:0] rt, input logic [63:0] rd);
    @(negedge clock);
    proc2Imem_command = ic; proc2Imem_addr = ia;
    proc2Dmem_command = dc; proc2Dmem_addr = da; proc2Dmem_data = dd;
    mem2proc_transaction_tag = mt; mem2proc_data_tag = rt; mem2proc_data = rd;
    #1;
  endtask

  task automatic cycle(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                       input logic [31:0] da, input logic [63:0] dd, input logic [3:0] mt,
                       input logic [3:0] rt, input logic [63:0] rd);
    apply(ic, ia, dc, da, dd, mt, rt, rd);
    check_model();
    step();
  endtask

  task automatic set_idle();
    proc2Imem_command = MEM_NONE; proc2Imem_addr = '0;
    proc2Dmem_command = MEM_NONE; proc2Dmem_addr = '0; proc2Dmem_data = '0;
    mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    set_idle();
    reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_stale", stale_tag_err, 1'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset held with live requests on every input: everything must stay quiet
    reset = 1'b0;
    proc2Imem_command = MEM_LOAD;  proc2Imem_addr = 32'h100;
    proc2Dmem_command = MEM_STORE; proc2Dmem_addr = 32'h200; proc2Dmem_data = 64'hDEAD;
    mem2proc_transaction_tag = 4'd3; mem2proc_data_tag = 4'd5; mem2proc_data = 64'hBEEF;
    repeat (2) @(negedge clock);
    #1;
    check_val("rst_cmd",   proc2mem_command,          MEM_NONE);
    check_val("rst_addr",  proc2mem_addr,             0);
    check_val("rst_wdata", proc2mem_data,             0);
    check_val("rst_i_tt",  Imem2proc_transaction_tag, 0);
    check_val("rst_d_tt",  Dmem2proc_transaction_tag, 0);
    check_val("rst_i_rt",  Imem2proc_data_tag,        0);
    check_val("rst_d_rt",  Dmem2proc_data_tag,        0);
    check_val("rst_i_rd",  Imem2proc_data,            0);
    check_val("rst_d_rd",  Dmem2proc_data,            0);
    check_val("rst_stale", stale_tag_err,             0);
    @(negedge clock);
    set_idle();
    reset = 1'b1;

    // First icache load after reset, accepted as tag 3
    apply(MEM_LOAD, 32'h100, MEM_NONE, 0, 0, 4'd3, 4'd0, 0);
    check_model();
    check_val("t1_addr", proc2mem_addr, 32'h100);
    check_val("t1_i_tt", Imem2proc_transaction_tag, 4'd3);
    check_val("t1_d_tt", Dmem2proc_transaction_tag, 4'd0);
    step();

    // Tag 3 returns to icache while a dcache load claims tag 3 in the same cycle
    apply(MEM_NONE, 0, MEM_LOAD, 32'h200, 0, 4'd3, 4'd3, 64'hAAAA);
    check_model();
    check_val("t6_i_rt", Imem2proc_data_tag, 4'd3);
    check_val("t6_i_rd", Imem2proc_data, 64'hAAAA);
    check_val("t6_d_rt", Dmem2proc_data_tag, 4'd0);
    check_val("t6_d_tt", Dmem2proc_transaction_tag, 4'd3);
    step();
    apply(MEM_NONE, 0, MEM_NONE, 0, 0, 4'd0, 4'd3, 64'hBBBB);
    check_model();
    check_val("t6b_d_rt", Dmem2proc_data_tag, 4'd3);
    check_val("t6b_d_rd", Dmem2proc_data, 64'hBBBB);
    check_val("t6b_i_rt", Imem2proc_data_tag, 4'd0);
    step();
    cycle(MEM_NONE, 0, MEM_NONE, 0, 0, 0, 0, 0);
    check_val("t6_stale", stale_tag_err, 1'b0);

    // Both loads every cycle: grants alternate starting with icache
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      apply(MEM_LOAD, 32'h1000 + k, MEM_LOAD, 32'h2000 + k, 64'h0, 4'(k + 1), 4'd0, 0);
      check_model();
      check_val("t2_addr", proc2mem_addr, (k % 2 == 0) ? 32'h1000 + k : 32'h2000 + k);
      check_val("t2_i_tt", Imem2proc_transaction_tag, (k % 2 == 0) ? k + 1 : 0);
      check_val("t2_d_tt", Dmem2proc_transaction_tag, (k % 2 == 1) ? k + 1 : 0);
      step();
    end
    apply(MEM_NONE, 0, MEM_NONE, 0, 0, 4'd0, 4'd2, 64'h2222);
    check_model();
    check_val("t2_d_rt", Dmem2proc_data_tag, 4'd2);
    check_val("t2_d_rd", Dmem2proc_data, 64'h2222);
    check_val("t2_i_rt", Imem2proc_data_tag, 4'd0);
    step();

    // Stores versus a waiting icache load: load wins only once the limit is reached
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      apply(MEM_LOAD, 32'h400, MEM_STORE, 32'h300 + k, 64'(k + 16), 4'd5, 4'd0, 0);
      check_model();
      check_val("t3_cmd", proc2mem_command, (k == 4) ? MEM_LOAD : MEM_STORE);
      check_val("t3_addr", proc2mem_addr, (k == 4) ? 32'h400 : 32'h300 + k);
      check_val("t3_wdata", proc2mem_data, (k == 4) ? 64'h0 : 64'(k + 16));
      check_val("t3_i_tt", Imem2proc_transaction_tag, (k == 4) ? 4'd5 : 4'd0);
      step();
    end

    // Rejected icache grants must not move the pointer
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      apply(MEM_LOAD, 32'h500, MEM_LOAD, 32'h600, 0, (k < 3) ? 4'd0 : 4'(k + 4), 4'd0, 0);
      check_model();
      check_val("t4_addr", proc2mem_addr, (k < 4) ? 32'h500 : 32'h600);
      check_val("t4_i_tt", Imem2proc_transaction_tag, (k == 3) ? 4'd7 : 4'd0);
      step();
    end
    apply(MEM_NONE, 0, MEM_NONE, 0, 0, 4'd0, 4'd7, 64'h7777);
    check_model();
    check_val("t4_i_rt", Imem2proc_data_tag, 4'd7);
    step();

    // Return of a tag nobody owns: sticky error, delivered to nobody
    apply(MEM_NONE, 0, MEM_NONE, 0, 0, 4'd0, 4'd5, 64'h5555);
    check_model();
    check_val("t5_i_rt", Imem2proc_data_tag, 4'd0);
    check_val("t5_d_rt", Dmem2proc_data_tag, 4'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      apply(MEM_NONE, 0, MEM_NONE, 0, 0, 4'd0, 4'd0, 0);
      check_model();
      check_val("t5_stale", stale_tag_err, 1'b1);
      step();
    end

    // Reset mid-transaction drops ownership; the late return is stale
    pulse_reset();
    cycle(MEM_NONE, 0, MEM_LOAD, 32'h900, 0, 4'd9, 4'd0, 0);
    pulse_reset();
    apply(MEM_NONE, 0, MEM_NONE, 0, 0, 4'd0, 4'd9, 64'h9999);
    check_model();
    check_val("rst_drop_d", Dmem2proc_data_tag, 4'd0);
    step();
    apply(MEM_NONE, 0, MEM_NONE, 0, 0, 4'd0, 4'd0, 0);
    check_model();
    check_val("rst_drop_stale", stale_tag_err, 1'b1);
    step();

    // Randomized traffic: legal tags for the first half, then protocol violations mixed in
    pulse_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [1:0] ic, dc;
      logic [3:0] mt, rt;
      int p;
      int cand[$];
      ic = ($urandom_range(0, 1) == 1) ? MEM_LOAD : MEM_NONE;
      case ($urandom_range(0, 2))
        0:       dc = MEM_NONE;
        1:       dc = MEM_LOAD;
        default: dc = MEM_STORE;
      endcase
      cand.delete();
      for (int t = 1; t < 16; t++) if (!m_vld[t]) cand.push_back(t);
      p = $urandom_range(0, 99);
      if (p < 20 || cand.size() == 0) mt = 4'd0;
      else mt = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      if (cyc >= 400 && p >= 95) mt = 4'($urandom_range(1, 15));
      cand.delete();
      for (int t = 1; t < 16; t++) if (m_vld[t]) cand.push_back(t);
      p = $urandom_range(0, 99);
      if (p < 40 && cand.size() > 0) rt = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      else rt = 4'd0;
      if (cyc >= 400 && p >= 97) rt = 4'($urandom_range(1, 15));
      cycle(ic, $urandom, dc, $urandom, {$urandom, $urandom}, mt, rt, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single processor-memory port between the icache miss path and the dcache (MSHR line fills and dirty-line writebacks).
- Grants one command per cycle and records which requester owns each outstanding load transaction tag.
- Routes each returning data tag and block back to its owner only.
- Sits between the icache/dcache memory-side ports and the top-level memory interface.

Parameters:
- NUM_TAGS, 16: number of memory transaction tags (tag 0 means "none/rejected"); owner table has NUM_TAGS entries.
- STARVE_LIMIT, 4: consecutive cycles a pending load may lose to a dcache store before loads get priority.
- CNT_WIDTH, 3: width of the starvation counter; must satisfy STARVE_LIMIT < 2^CNT_WIDTH.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- proc2Imem_command  input  2  icache request (MEM_NONE/MEM_LOAD)
- proc2Imem_addr  input  32  icache block address
- proc2Dmem_command  input  2  dcache request (MEM_NONE/MEM_LOAD/MEM_STORE)
- proc2Dmem_addr  input  32  dcache block address
- proc2Dmem_data  input  64  dcache writeback block
- mem2proc_transaction_tag  input  4  memory accept tag for this cycle's command, 0 = rejected
- mem2proc_data  input  64  returning block
- mem2proc_data_tag  input  4  tag of returning block, 0 = none
- proc2mem_command  output  2  granted command
- proc2mem_addr  output  32  granted address
- proc2mem_data  output  64  granted store data
- Imem2proc_transaction_tag  output  4  accept tag to icache, 0 if not granted or rejected
- Imem2proc_data  output  64  block to icache
- Imem2proc_data_tag  output  4  data tag to icache, 0 unless icache owns it
- Dmem2proc_transaction_tag  output  4  accept tag to dcache
- Dmem2proc_data  output  64  block to dcache
- Dmem2proc_data_tag  output  4  data tag to dcache, 0 unless dcache owns it
- stale_tag_err  output  1  sticky: data tag arrived with no valid owner

Behaviour:
- Reset (reset==0, asynchronous):
  - Owner table cleared: all valid=0.
  - Round-robin pointer set to ICACHE.
  - Starvation counter = 0; stale_tag_err = 0.
  - All outputs driven 0 / MEM_NONE while reset is held.
  - Reset asserted mid-transaction discards all ownership; later returns of pre-reset tags set stale_tag_err and are delivered to nobody.
- Arbitration is combinational; the grant, the forwarded command and the accept-tag return all happen in the same cycle.
- Default priority: dcache MEM_STORE first, then round-robin between dcache MEM_LOAD and icache MEM_LOAD.
- Round-robin pointer:
  - Flips to the other load requester only when a load grant is accepted (mem2proc_transaction_tag != 0).
  - A rejected grant leaves the pointer unchanged.
- Starvation:
  - Counter increments each cycle a dcache store is accepted while any load request is present.
  - Counter clears when any load is accepted, or when no load is pending.
  - When counter == STARVE_LIMIT, loads outrank the store for that cycle.
  - The counter clears once a load is accepted.
- Forwarding:
  - The granted requester's command/addr/data drive proc2mem_*.
  - For an icache grant, proc2mem_data = 0.
  - Only the granted requester sees mem2proc_transaction_tag on its *_transaction_tag output; the other sees 0.
- Owner table:
  - On an accepted MEM_LOAD, entry[tag] <= {valid=1, owner}.
  - Stores are not recorded, since no data returns for them.
- Data return with mem2proc_data_tag != 0:
  - If entry valid, forward tag+data to the owner only, and clear the entry at the clock edge.
  - If entry invalid, set stale_tag_err and forward to nobody.
  - Non-owner data outputs are 0.
- Same tag returned and reallocated in one cycle: the allocation wins, and the entry ends valid with the new owner.
- Allocation of a tag whose entry is already valid: overwrite the entry and set stale_tag_err (memory protocol violation).
- No requests: proc2mem_command = MEM_NONE, addr/data = 0, counter clears.
- Data return and grant are independent and may occur in the same cycle.

Test Plan:
- Reset held low with active requests -> all outputs 0/MEM_NONE; after release with icache LOAD 0x100 and mem tag 3 -> proc2mem_addr=0x100, Imem2proc_transaction_tag=3, Dmem2proc_transaction_tag=0.
- Both loads each cycle, memory tags 1,2,3,4 -> grants alternate icache, dcache, icache, dcache; later data_tag=2 appears only on Dmem2proc_data_tag with matching block.
- Dcache STORE and icache LOAD both present for 6 cycles, STARVE_LIMIT=4 -> stores granted cycles 0-3, icache load granted cycle 4, store cycle 5.
- Icache load rejected (tag 0) for 3 cycles then accepted with tag 7 -> pointer unchanged until cycle 3; the owner table then marks tag 7 as icache.
- Data_tag=5 with no outstanding tag 5 -> stale_tag_err rises and stays 1; neither *_data_tag output nonzero.
- Data_tag=3 return coinciding with a new dcache load accepted as tag 3 -> return goes to the old owner (icache); the next data_tag=3 goes to dcache.
